// File: rtl/demux2_16_pkg.sv
// rtl/demux2_16_pkg.sv - shared defaults and word type for the 1-to-2 route demux
package demux2_16_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 2;
  localparam int PTR_W     = $clog2(DEPTH_DEF);

  typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/demux_fifo.sv
// rtl/demux_fifo.sv - synchronous FIFO (push/pop/full/empty) buffering one demux output
module demux_fifo
  import demux2_16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  // Empty buffer presents zero so stale storage never leaks out after reset.
  assign head_data = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/demux2_16_route.sv
// rtl/demux2_16_route.sv - route each input word to out0 (s=1) or out1 (s=0) through per-output FIFOs
// Optional delivered-word counters enabled by macro DEMUX2_16_ROUTE_CNT_EN.
module demux2_16_route
  import demux2_16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  logic w_full0, w_full1;
  logic w_empty0, w_empty1;
  logic w_accept, w_push0, w_push1, w_pop0, w_pop1;

  // Readiness follows the currently selected buffer only; a pop in the same cycle does not help.
  assign in_ready = rst_n & ~(s ? w_full0 : w_full1);
  assign w_accept = in_valid & in_ready;
  assign w_push0  = w_accept & s;
  assign w_push1  = w_accept & ~s;
  assign w_pop0   = out0_ready & ~w_empty0;
  assign w_pop1   = out1_ready & ~w_empty1;

  assign out0_valid = ~w_empty0;
  assign out1_valid = ~w_empty1;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push0),
    .push_data (in_data),
    .pop       (w_pop0),
    .full      (w_full0),
    .empty     (w_empty0),
    .head_data (out0_data)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push1),
    .push_data (in_data),
    .pop       (w_pop1),
    .full      (w_full1),
    .empty     (w_empty1),
    .head_data (out1_data)
  );

`ifdef DEMUX2_16_ROUTE_CNT_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_pop0) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_pop1) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule
